// File: rtl/arb_pkg.sv
// Shared types and default widths for the core memory-port arbiter.
package arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_MASK_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        ARB_OWNER_IFU,
        ARB_OWNER_LSU
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between IFU and LSU requests.
// With ARB_ROUND_ROBIN_EN defined, simultaneous requests go to whichever
// requester did not win last; otherwise LSU always beats IFU.
module arb_pick
    import arb_pkg::*;
(
    input  logic       ifu_req_i,
    input  logic       lsu_req_i,
    input  arb_owner_t last_owner_i,
    output arb_owner_t grant_o
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at history; keep the port tied off cleanly.
    logic unused_last_owner;
    assign unused_last_owner = (last_owner_i == ARB_OWNER_LSU);
`endif

    // Pick the owner of the next transaction; only meaningful when a request is present.
    always_comb begin
        // NOTE: give every combinational output a default first so no path leaves it unassigned (which would infer a latch).
        grant_o = ARB_OWNER_IFU;
`ifdef ARB_ROUND_ROBIN_EN
        if (ifu_req_i && lsu_req_i) begin
            grant_o = (last_owner_i == ARB_OWNER_LSU) ? ARB_OWNER_IFU : ARB_OWNER_LSU;
        end else if (lsu_req_i) begin
            grant_o = ARB_OWNER_LSU;
        end else if (ifu_req_i) begin
            grant_o = ARB_OWNER_IFU;
        end
`else
        if (lsu_req_i) begin
            grant_o = ARB_OWNER_LSU;
        end else if (ifu_req_i) begin
            grant_o = ARB_OWNER_IFU;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single core memory port between the IFU (read-only) and the
// LSU (read/write). One transaction at a time: grant, issue, wait for the
// response, route it back to the owner. The request is captured at grant
// so the downstream fields stay stable while the owner waits.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating arbitration
// on simultaneous requests (default is fixed LSU-over-IFU priority).
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int MASK_W = ARB_MASK_W
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              ifu_reqValid,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_respValid,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_reqValid,
    input  logic              lsu_wen,
    input  logic [MASK_W-1:0] lsu_wmask,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_respValid,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_reqValid,
    input  logic              mem_reqReady,
    output logic              mem_wen,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_respValid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              wen_q, wen_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    arb_owner_t        grant;
    arb_owner_t        pick_last;
    logic              completing;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t        last_owner_q, last_owner_d;
    assign pick_last = last_owner_q;
`else
    assign pick_last = ARB_OWNER_IFU;
`endif

    arb_pick u_pick (
        .ifu_req_i    (ifu_reqValid),
        .lsu_req_i    (lsu_reqValid),
        .last_owner_i (pick_last),
        .grant_o      (grant)
    );

    // Next-state logic: grant and capture in IDLE, handshake in REQ, completion in REQ/WAIT.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wen_d      = wen_q;
        wmask_d    = wmask_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        completing = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif

        case (state_q)
            ARB_IDLE: begin
                if (ifu_reqValid || lsu_reqValid) begin
                    state_d = ARB_REQ;
                    owner_d = grant;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = grant;
`endif
                    if (grant == ARB_OWNER_LSU) begin
                        wen_d   = lsu_wen;
                        wmask_d = lsu_wen ? lsu_wmask : '0;
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                    end else begin
                        wen_d   = 1'b0;
                        wmask_d = '0;
                        addr_d  = ifu_addr;
                        wdata_d = '0;
                    end
                end
            end
            ARB_REQ: begin
                if (mem_reqReady) begin
                    if (mem_respValid) begin
                        completing = 1'b1;
                        state_d    = ARB_IDLE;
                    end else begin
                        state_d    = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                if (mem_respValid) begin
                    completing = 1'b1;
                    state_d    = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and captured request registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWNER_IFU;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= ARB_OWNER_IFU;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign mem_reqValid  = (state_q == ARB_REQ);
    assign mem_wen       = wen_q;
    assign mem_wmask     = wmask_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

    // Responses only reach the owner while a transaction is completing; stray pulses vanish.
    assign ifu_respValid = completing && (owner_q == ARB_OWNER_IFU);
    assign lsu_respValid = completing && (owner_q == ARB_OWNER_LSU);
    assign ifu_rdata     = ifu_respValid ? mem_rdata : '0;
    assign lsu_rdata     = lsu_respValid ? mem_rdata : '0;

endmodule
